// File: rtl/mac_wb_arb_pkg.sv
// Shared types for the MAC write-back merge stage.
//   XLEN            datapath width of results and instruction tags
//   mac_wb_entry_t  one queued MAC result: data, destination rd, tag, instruction word
//   wb_src_e        which source produced the current write-back beat
//   rd_onehot()     one-hot decode of a destination register index
package mac_wb_arb_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
    } mac_wb_entry_t;

    typedef enum logic {
        WB_MAIN = 1'b0,
        WB_MAC  = 1'b1
    } wb_src_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/mac_wb_fifo.sv
// Small synchronous FIFO holding MAC results that lost the write port.
//   clk, rst   clock and synchronous active-high reset (discards contents)
//   push_i     write entry_i at the tail
//   entry_i    entry to enqueue
//   pop_i      drop the head entry
//   head_o     current head entry (valid while !empty_o)
//   full_o     count == DEPTH
//   empty_o    count == 0
//   count_o    number of valid entries
//   valid_o    per-slot valid bits, used to build the pending-rd mask
//   rd_o       per-slot destination register
// The caller never pushes while full nor pops while empty.
module mac_wb_fifo
    import mac_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  mac_wb_entry_t           entry_i,
    input  logic                    pop_i,
    output mac_wb_entry_t           head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CW-1:0]           count_o,
    output logic [DEPTH-1:0]        valid_o,
    output logic [DEPTH-1:0][4:0]   rd_o
);

    mac_wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;

    // Next-state for pointers, count and slot valid bits. Pointers wrap
    // naturally because DEPTH is a power of two. A simultaneous push and pop
    // never hit the same slot unless the FIFO is full, which the caller
    // prevents, so clearing before setting is only a safety ordering.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage needs no reset: slot contents are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Expose per-slot destinations for the pending-register mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_o[i] = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mac_wb_arb.sv
// Write-back merge of MAC results into the register-file write port shared
// with the main EXU pipe. The main pipe always wins; MAC results queue in a
// FIFO and drain on idle port cycles, or bypass it when it is empty.
//   clk, rst                 clock, synchronous active-high reset
//   mac_freeze               freeze actually applied to the MAC
//   mac_out/rd_addr/rd_wr_en/instr_tag/instr   MAC result beat
//   main_wr_en/data/rd_addr/instr_tag/instr    main-pipe write beat
//   mac_hold                 freeze request to the MAC (FIFO full)
//   exu_hold                 ask the main pipe to leave next cycle idle
//   pend_mask                registers targeted by queued MAC results
//   wb_*                     registered write-back beat, wb_from_mac = source
// Optional feature macro: MAC_WB_ANTISTARVE_EN enables the starvation counter
// that drives exu_hold; without it exu_hold is tied low.
module mac_wb_arb
    import mac_wb_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mac_freeze,
    input  logic [XLEN-1:0] mac_out,
    input  logic [4:0]      mac_rd_addr,
    input  logic            mac_rd_wr_en,
    input  logic [XLEN-1:0] mac_instr_tag,
    input  logic [31:0]     mac_instr,
    input  logic            main_wr_en,
    input  logic [XLEN-1:0] main_data,
    input  logic [4:0]      main_rd_addr,
    input  logic [XLEN-1:0] main_instr_tag,
    input  logic [31:0]     main_instr,
    output logic            mac_hold,
    output logic            exu_hold,
    output logic [31:0]     pend_mask,
    output logic            wb_wr_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_instr_tag,
    output logic [31:0]     wb_instr,
    output logic            wb_from_mac
);

    localparam int CW = $clog2(DEPTH) + 1;

    mac_wb_entry_t           mac_entry, fifo_head;
    logic                    fifo_full, fifo_empty, fifo_push;
    logic [CW-1:0]           fifo_count;
    logic [DEPTH-1:0]        fifo_valid;
    logic [DEPTH-1:0][4:0]   fifo_rd;
    logic                    push_ok, pop, bypass;

    mac_wb_entry_t           wb_q, wb_d;
    logic                    wb_wr_en_q, wb_wr_en_d;
    wb_src_e                 wb_src_q, wb_src_d;

    assign mac_entry = '{data: mac_out, rd: mac_rd_addr, tag: mac_instr_tag, instr: mac_instr};

    // A result is taken only when the MAC is not frozen and there is room;
    // results aimed at x0 are swallowed here and never reach the port.
    assign push_ok   = mac_rd_wr_en & ~mac_freeze & ~fifo_full & (mac_rd_addr != 5'd0);
    assign pop       = ~main_wr_en & ~fifo_empty;
    assign bypass    = ~main_wr_en & fifo_empty & push_ok;
    assign fifo_push = push_ok & ~bypass;
    assign mac_hold  = fifo_full;

    mac_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .entry_i (mac_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .valid_o (fifo_valid),
        .rd_o    (fifo_rd)
    );

    // Pending mask covers queued entries only; bypassed beats never appear.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pend_mask = pend_mask | rd_onehot(fifo_rd[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Port grant: main pipe first, then the FIFO head, then a bypassing push.
    // On idle cycles only the enable drops; the payload holds its last value.
    always_comb begin
        wb_d       = wb_q;
        wb_src_d   = wb_src_q;
        wb_wr_en_d = main_wr_en | pop | bypass;
        if (main_wr_en) begin
            wb_d     = '{data: main_data, rd: main_rd_addr, tag: main_instr_tag, instr: main_instr};
            wb_src_d = WB_MAIN;
        end else if (pop) begin
            wb_d     = fifo_head;
            wb_src_d = WB_MAC;
        end else if (bypass) begin
            wb_d     = mac_entry;
            wb_src_d = WB_MAC;
        end
    end

    // Write-back beat register: one cycle of latency for either source.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= '0;
            wb_src_q   <= WB_MAIN;
            wb_wr_en_q <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            wb_src_q   <= wb_src_d;
            wb_wr_en_q <= wb_wr_en_d;
        end
    end

    assign wb_wr_en     = wb_wr_en_q;
    assign wb_data      = wb_q.data;
    assign wb_rd_addr   = wb_q.rd;
    assign wb_instr_tag = wb_q.tag;
    assign wb_instr     = wb_q.instr;
    assign wb_from_mac  = (wb_src_q == WB_MAC);

`ifdef MAC_WB_ANTISTARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    // Count cycles the head waits behind main traffic. The counter saturates
    // one past the hold point so exu_hold pulses once even if the main pipe
    // ignores it; any pop or an empty FIFO restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (main_wr_en && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign exu_hold = ~fifo_empty & (starve_q == SW'(STARVE_LIMIT - 1));
`else
    // Without the starvation counter the limit has no consumer.
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign exu_hold = 1'b0;
`endif

    // The FIFO occupancy can never exceed its depth.
    assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_mac_wb_arb.sv
// Directed self-checking bench for mac_wb_arb. Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point, so each
// check observes the registered result of the previous cycle's inputs.
// mac_freeze is modelled as an upstream freeze OR'd with mac_hold.
module tb_mac_wb_arb;
    import mac_wb_arb_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            freeze_g;
    logic            mac_freeze;
    logic [XLEN-1:0] mac_out;
    logic [4:0]      mac_rd_addr;
    logic            mac_rd_wr_en;
    logic [XLEN-1:0] mac_instr_tag;
    logic [31:0]     mac_instr;
    logic            main_wr_en;
    logic [XLEN-1:0] main_data;
    logic [4:0]      main_rd_addr;
    logic [XLEN-1:0] main_instr_tag;
    logic [31:0]     main_instr;
    logic            mac_hold;
    logic            exu_hold;
    logic [31:0]     pend_mask;
    logic            wb_wr_en;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_instr_tag;
    logic [31:0]     wb_instr;
    logic            wb_from_mac;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mac_freeze = freeze_g | mac_hold;

    mac_wb_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mac_freeze     (mac_freeze),
        .mac_out        (mac_out),
        .mac_rd_addr    (mac_rd_addr),
        .mac_rd_wr_en   (mac_rd_wr_en),
        .mac_instr_tag  (mac_instr_tag),
        .mac_instr      (mac_instr),
        .main_wr_en     (main_wr_en),
        .main_data      (main_data),
        .main_rd_addr   (main_rd_addr),
        .main_instr_tag (main_instr_tag),
        .main_instr     (main_instr),
        .mac_hold       (mac_hold),
        .exu_hold       (exu_hold),
        .pend_mask      (pend_mask),
        .wb_wr_en       (wb_wr_en),
        .wb_data        (wb_data),
        .wb_rd_addr     (wb_rd_addr),
        .wb_instr_tag   (wb_instr_tag),
        .wb_instr       (wb_instr),
        .wb_from_mac    (wb_from_mac)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze_g       = 1'b0;
        mac_rd_wr_en   = 1'b0;
        mac_out        = '0;
        mac_rd_addr    = '0;
        mac_instr_tag  = '0;
        mac_instr      = '0;
        main_wr_en     = 1'b0;
        main_data      = '0;
        main_rd_addr   = '0;
        main_instr_tag = '0;
        main_instr     = '0;
    endtask

    task automatic mac_beat(input logic [4:0] rd, input logic [31:0] data);
        mac_rd_wr_en  = 1'b1;
        mac_rd_addr   = rd;
        mac_out       = data;
        mac_instr_tag = 32'hC000_0000 | data;
        mac_instr     = 32'h0200_0033;
    endtask

    task automatic main_beat(input logic [4:0] rd, input logic [31:0] data);
        main_wr_en     = 1'b1;
        main_rd_addr   = rd;
        main_data      = data;
        main_instr_tag = 32'hA000_0000 | data;
        main_instr     = 32'h0000_0013;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, wb_instr_tag, wb_instr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_wb: got en=%b mac=%b rd=%0d data=%h tag=%h instr=%h, expected all 0",
                     wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, wb_instr_tag, wb_instr);
        end
        checks++;
        if ({mac_hold, exu_hold, pend_mask} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got mac_hold=%b exu_hold=%b pend=%h, expected 0 0 0",
                     mac_hold, exu_hold, pend_mask);
        end
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        idle_inputs();
        mac_beat(5'd5, 32'h1234);
        checks++;
        if (pend_mask !== 32'h0) begin
            errors++;
            $display("[TB] FAIL bypass_pend_same_cycle: got %h expected 0", pend_mask);
        end
        tick();
        idle_inputs();
        checks++;
        if ({wb_wr_en, wb_from_mac, wb_rd_addr, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
            errors++;
            $display("[TB] FAIL bypass_wb: got en=%b mac=%b rd=%0d data=%h, expected 1 1 5 00001234",
                     wb_wr_en, wb_from_mac, wb_rd_addr, wb_data);
        end
        checks++;
        if ({wb_instr_tag, wb_instr} !== {32'hC000_1234, 32'h0200_0033}) begin
            errors++;
            $display("[TB] FAIL bypass_tag: got tag=%h instr=%h expected c0001234 02000033",
                     wb_instr_tag, wb_instr);
        end
        checks++;
        if (pend_mask !== 32'h0) begin
            errors++;
            $display("[TB] FAIL bypass_pend: got %h expected 0", pend_mask);
        end
        tick();
        checks++;
        if ({wb_wr_en, wb_data, wb_from_mac} !== {1'b0, 32'h1234, 1'b1}) begin
            errors++;
            $display("[TB] FAIL idle_hold_payload: got en=%b data=%h mac=%b expected 0 00001234 1",
                     wb_wr_en, wb_data, wb_from_mac);
        end
    endtask

    task automatic test_main_wins_and_drain();
        logic [31:0] exp_pend;
        idle_inputs();
        exp_pend = 32'h0;
        for (int k = 0; k < 6; k++) begin
            main_beat(5'd20, 32'h1000 + k);
            if (k < 4) begin
                mac_beat(5'(k + 1), 32'h100 + k + 1);
            end else begin
                mac_rd_wr_en = 1'b0;
            end
            tick();
            checks++;
            if ({wb_wr_en, wb_from_mac, wb_rd_addr, wb_data} !== {1'b1, 1'b0, 5'd20, 32'h1000 + k}) begin
                errors++;
                $display("[TB] FAIL main_wins[%0d]: got en=%b mac=%b rd=%0d data=%h expected 1 0 20 %h",
                         k, wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, 32'h1000 + k);
            end
            if (k < 4) begin
                exp_pend = exp_pend | (32'd1 << (k + 1));
            end
            checks++;
            if ({mac_hold, pend_mask} !== {(k >= 3), exp_pend}) begin
                errors++;
                $display("[TB] FAIL queue_fill[%0d]: got hold=%b pend=%h expected %b %h",
                         k, mac_hold, pend_mask, (k >= 3), exp_pend);
            end
        end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_pend = exp_pend & ~(32'd1 << k);
            checks++;
            if ({wb_wr_en, wb_from_mac, wb_rd_addr, wb_data} !== {1'b1, 1'b1, 5'(k), 32'h100 + k}) begin
                errors++;
                $display("[TB] FAIL drain[%0d]: got en=%b mac=%b rd=%0d data=%h expected 1 1 %0d %h",
                         k, wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, k, 32'h100 + k);
            end
            checks++;
            if ({mac_hold, pend_mask} !== {1'b0, exp_pend}) begin
                errors++;
                $display("[TB] FAIL drain_pend[%0d]: got hold=%b pend=%h expected 0 %h",
                         k, mac_hold, pend_mask, exp_pend);
            end
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_done: got wb_wr_en=%b expected 0", wb_wr_en);
        end
    endtask

    task automatic test_full_pop();
        logic [4:0]  exp_rd [5];
        logic [31:0] exp_pend [5];
        exp_rd   = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
        exp_pend = '{32'h380, 32'h700, 32'h600, 32'h400, 32'h0};
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            main_beat(5'd21, 32'h2000);
            mac_beat(5'(6 + k), 32'h600 + k);
            tick();
        end
        checks++;
        if ({mac_hold, pend_mask} !== {1'b1, 32'h3C0}) begin
            errors++;
            $display("[TB] FAIL full_state: got hold=%b pend=%h expected 1 000003c0", mac_hold, pend_mask);
        end
        idle_inputs();
        mac_beat(5'd10, 32'hAAA);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) begin
                mac_rd_wr_en = 1'b0;
            end
            checks++;
            if ({wb_wr_en, wb_from_mac, wb_rd_addr, mac_hold, pend_mask} !==
                {1'b1, 1'b1, exp_rd[k], 1'b0, exp_pend[k]}) begin
                errors++;
                $display("[TB] FAIL full_pop[%0d]: got en=%b mac=%b rd=%0d hold=%b pend=%h expected 1 1 %0d 0 %h",
                         k, wb_wr_en, wb_from_mac, wb_rd_addr, mac_hold, pend_mask, exp_rd[k], exp_pend[k]);
            end
        end
        checks++;
        if (wb_data !== 32'hAAA) begin
            errors++;
            $display("[TB] FAIL late_push_data: got %h expected 00000aaa", wb_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        mac_beat(5'd0, 32'h55);
        tick();
        checks++;
        if ({wb_wr_en, pend_mask} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL rd0_bypass: got en=%b pend=%h expected 0 0", wb_wr_en, pend_mask);
        end
        main_beat(5'd22, 32'h3000);
        tick();
        idle_inputs();
        checks++;
        if ({wb_from_mac, pend_mask, mac_hold} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rd0_queue: got mac=%b pend=%h hold=%b expected 0 0 0",
                     wb_from_mac, pend_mask, mac_hold);
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd0_no_drain: got wb_wr_en=%b expected 0", wb_wr_en);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            main_beat(5'd23, 32'h4000);
            mac_beat(5'(11 + k), 32'h700 + k);
            tick();
        end
        checks++;
        if (pend_mask !== 32'h3800) begin
            errors++;
            $display("[TB] FAIL pre_reset_pend: got %h expected 00003800", pend_mask);
        end
        mac_rd_wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if ({wb_wr_en, pend_mask, mac_hold} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got en=%b pend=%h hold=%b expected 0 0 0",
                     wb_wr_en, pend_mask, mac_hold);
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_discard: got wb_wr_en=%b expected 0", wb_wr_en);
        end
    endtask

    task automatic test_antistarve();
        idle_inputs();
        main_beat(5'd24, 32'h5000);
        mac_beat(5'd3, 32'h333);
        tick();
        mac_rd_wr_en = 1'b0;
`ifdef MAC_WB_ANTISTARVE_EN
        for (int n = 1; n <= 8; n++) begin
            checks++;
            if (exu_hold !== (n == 8)) begin
                errors++;
                $display("[TB] FAIL exu_hold[%0d]: got %b expected %b", n, exu_hold, (n == 8));
            end
            tick();
        end
        main_wr_en = 1'b0;
        checks++;
        if (exu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exu_hold_pulse: got %b expected 0", exu_hold);
        end
`else
        for (int n = 1; n <= 10; n++) begin
            checks++;
            if (exu_hold !== 1'b0) begin
                errors++;
                $display("[TB] FAIL exu_hold_off[%0d]: got %b expected 0", n, exu_hold);
            end
            tick();
        end
        main_wr_en = 1'b0;
`endif
        tick();
        checks++;
        if ({wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, pend_mask} !==
            {1'b1, 1'b1, 5'd3, 32'h333, 32'h0}) begin
            errors++;
            $display("[TB] FAIL starve_retire: got en=%b mac=%b rd=%0d data=%h pend=%h expected 1 1 3 00000333 0",
                     wb_wr_en, wb_from_mac, wb_rd_addr, wb_data, pend_mask);
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_main_wins_and_drain();
        test_full_pop();
        test_rd_zero();
        test_reset_mid();
        test_antistarve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
